// File: rtl/mem_ctrl_arb_pkg.sv
// Shared encodings for the memory controller: FSM states, access sizes and byte-lane width.
// The helper maps a size code to the index of the last byte in the access.
package mem_ctrl_arb_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // The reserved code 11 falls through to a word access.
    function automatic logic [CNT_W-1:0] last_byte(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after the pointer, wrapping.
// Produces both a one-hot grant and the granted index; no grant while disabled.
module mem_ctrl_arb_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx
);

    int   w_j;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= NUM_CH) begin
                w_j = w_j - NUM_CH;
            end
            if (i_en && !w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-channel memory controller: round-robin arbitration and byte-serial loads/stores
// on a byte-wide RAM bus with one cycle of read latency, little-endian assembly.
module mem_ctrl_arb
    import mem_ctrl_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [2*NUM_CH-1:0]      size_i,
    input  logic [NUM_CH-1:0]        sext_i,
    input  logic [ADDR_W*NUM_CH-1:0] addr_i,
    input  logic [DATA_W*NUM_CH-1:0] wdata_i,
    output logic [NUM_CH-1:0]        done_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    input  logic [BYTE_W-1:0]        mem_din,
    output logic [BYTE_W-1:0]        mem_dout,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_wr
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_CH-1:0]   r_gnt_oh;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_last;
    logic                r_sext;
    logic [DATA_W-1:0]   r_wshift;
    logic [CNT_W-1:0]    r_ic;
    logic [CNT_W-1:0]    r_cc;
    logic                r_iss;
    logic                r_dvld;
    logic                r_paused;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_rdata_o;
    logic [ADDR_W-1:0]   r_addr;
    logic [BYTE_W-1:0]   r_dout;
    logic                r_wr;
    logic                r_busy;
    logic [NUM_CH-1:0]   r_done;

    logic [NUM_CH-1:0]   w_gnt_oh;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_arb_en;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [1:0]          w_sel_size;
    logic                w_sel_we;
    logic                w_sel_sext;
    logic                w_rewind;
    logic [CNT_W-1:0]    w_ic;
    logic                w_cap;
    logic                w_iss;
    logic                w_more;
    logic [CNT_W-1:0]    w_next_ic;
    logic [DATA_W-1:0]   w_merged;

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [CNT_W-1:0] last,
                                                 input logic sx);
        logic [DATA_W-1:0] res;
        int                msb;
        res = d;
        msb = BYTE_W * (int'(last) + 1) - 1;
        for (int b = 0; b < DATA_W; b++) begin
            if (b > msb) begin
                res[b] = sx & d[msb];
            end
        end
        return res;
    endfunction

    assign w_arb_en = (r_state == ST_IDLE) && rdy_in;

    mem_ctrl_arb_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .i_req  (req_i),
        .i_ptr  (r_ptr),
        .i_en   (w_arb_en),
        .o_gnt  (w_gnt_oh),
        .o_idx  (w_gnt_idx)
    );

    assign w_sel_addr  = addr_i[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = wdata_i[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sel_size  = size_i[2*int'(w_gnt_idx) +: 2];
    assign w_sel_we    = we_i[w_gnt_idx];
    assign w_sel_sext  = sext_i[w_gnt_idx];

    // First cycle after a pause re-issues the oldest uncaptured byte; mem_din is stale then.
    assign w_rewind  = r_paused && rdy_in && (r_state == ST_RD);
    assign w_ic      = w_rewind ? r_cc : r_ic;
    assign w_cap     = r_dvld && !w_rewind;
    assign w_iss     = w_rewind || r_iss;
    assign w_more    = (w_ic != r_last);
    assign w_next_ic = w_more ? w_ic + CNT_W'(1) : w_ic;

    always_comb begin
        w_merged = r_rdata;
        w_merged[BYTE_W*int'(r_cc) +: BYTE_W] = mem_din;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IDX_W'(NUM_CH - 1);
            r_gnt_oh  <= '0;
            r_base    <= '0;
            r_last    <= '0;
            r_sext    <= 1'b0;
            r_wshift  <= '0;
            r_ic      <= '0;
            r_cc      <= '0;
            r_iss     <= 1'b0;
            r_dvld    <= 1'b0;
            r_paused  <= 1'b0;
            r_rdata   <= '0;
            r_rdata_o <= '0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= '0;
        end else if (!rdy_in) begin
            if (r_state == ST_RD) begin
                r_paused <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt_oh) begin
                        r_ptr    <= w_gnt_idx;
                        r_gnt_oh <= w_gnt_oh;
                        r_base   <= w_sel_addr;
                        r_addr   <= w_sel_addr;
                        r_last   <= last_byte(w_sel_size);
                        r_sext   <= w_sel_sext;
                        r_ic     <= '0;
                        r_cc     <= '0;
                        r_iss    <= 1'b1;
                        r_dvld   <= 1'b0;
                        r_paused <= 1'b0;
                        r_rdata  <= '0;
                        r_busy   <= 1'b1;
                        if (w_sel_we) begin
                            r_state  <= ST_WR;
                            r_dout   <= w_sel_wdata[BYTE_W-1:0];
                            r_wshift <= w_sel_wdata >> BYTE_W;
                            r_wr     <= 1'b1;
                        end else begin
                            r_state  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_paused <= 1'b0;
                    r_dvld   <= w_iss;
                    r_iss    <= w_more;
                    r_ic     <= w_next_ic;
                    r_addr   <= r_base + ADDR_W'(w_next_ic);
                    if (w_cap) begin
                        r_rdata <= w_merged;
                        r_cc    <= r_cc + CNT_W'(1);
                        if (r_cc == r_last) begin
                            r_state   <= ST_DONE;
                            r_done    <= r_gnt_oh;
                            r_busy    <= 1'b0;
                            r_rdata_o <= extend(w_merged, r_last, r_sext);
                        end
                    end
                end
                ST_WR: begin
                    if (r_ic == r_last) begin
                        r_state <= ST_DONE;
                        r_wr    <= 1'b0;
                        r_done  <= r_gnt_oh;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ic     <= r_ic + CNT_W'(1);
                        r_addr   <= r_base + ADDR_W'(r_ic + CNT_W'(1));
                        r_dout   <= r_wshift[BYTE_W-1:0];
                        r_wshift <= r_wshift >> BYTE_W;
                    end
                end
                default: begin
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr = w_rewind ? r_base + ADDR_W'(r_cc) : r_addr;
    assign mem_wr   = r_wr && rdy_in;
    assign mem_dout = r_dout;
    assign done_o   = r_done;
    assign busy_o   = r_busy;
    assign rdata_o  = r_rdata_o;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Directed bench for mem_ctrl_arb with a byte-wide RAM model (one cycle read latency).
// Each step drives inputs just after a rising edge and checks outputs one time unit later.
module tb_mem_ctrl_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  size;
    logic [1:0]  sext;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_addr;
    logic        mem_wr;

    int n_assert = 0;
    int n_fail   = 0;
    int c;
    int c2;

    logic [7:0] ram [bit [31:0]];
    bit         preloaded = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl_arb #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .req_i    (req),
        .we_i     (we),
        .size_i   (size),
        .sext_i   (sext),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .done_o   (done),
        .rdata_o  (rdata),
        .busy_o   (busy),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            ram[32'h100]   = 8'h78;
            ram[32'h101]   = 8'h56;
            ram[32'h102]   = 8'h34;
            ram[32'h103]   = 8'h12;
            ram[32'h200]   = 8'h11;
            ram[32'h201]   = 8'h22;
            ram[32'h202]   = 8'h33;
            ram[32'h203]   = 8'h44;
            ram[32'h30000] = 8'h80;
            preloaded      = 1'b1;
        end
        mem_din <= ram_rd(mem_addr);
        if (mem_wr) ram[mem_addr] = mem_dout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done === 2'b00 && cyc < limit) begin
            step();
            cyc++;
        end
    endtask

    task automatic set_ch(input int ch, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d);
        we[ch]            = w;
        size[2*ch +: 2]   = sz;
        sext[ch]          = sx;
        addr[32*ch +: 32] = a;
        wdata[32*ch +: 32] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        req   = 2'b00;
        we    = 2'b00;
        size  = 4'b0000;
        sext  = 2'b00;
        addr  = '0;
        wdata = '0;
        step();
        step();
        check("rst_done",  done,     2'b00);
        check("rst_rdata", rdata,    32'h0);
        check("rst_busy",  busy,     1'b0);
        check("rst_addr",  mem_addr, 32'h0);
        check("rst_wr",    mem_wr,   1'b0);
        check("rst_dout",  mem_dout, 8'h00);
        rst_n = 1'b1;

        // Load word from channel 0
        set_ch(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        req = 2'b01;
        step();
        check("t1_busy",  busy,     1'b1);
        check("t1_addr0", mem_addr, 32'h100);
        check("t1_nowr",  mem_wr,   1'b0);
        step();
        check("t1_addr1", mem_addr, 32'h101);
        step();
        check("t1_addr2", mem_addr, 32'h102);
        step();
        check("t1_addr3", mem_addr, 32'h103);
        step();
        check("t1_early", done,     2'b00);
        step();
        check("t1_done",  done,     2'b01);
        check("t1_rdata", rdata,    32'h12345678);
        check("t1_idle",  busy,     1'b0);
        req = 2'b00;
        step();
        check("t1_pulse", done,     2'b00);

        // Store half from channel 1 across a 64K boundary
        set_ch(1, 1'b1, 2'b01, 1'b0, 32'h1FFFF, 32'h0000BEEF);
        req = 2'b10;
        step();
        check("t2_addr0", mem_addr, 32'h1FFFF);
        check("t2_dout0", mem_dout, 8'hEF);
        check("t2_wr0",   mem_wr,   1'b1);
        step();
        check("t2_addr1", mem_addr, 32'h20000);
        check("t2_dout1", mem_dout, 8'hBE);
        check("t2_wr1",   mem_wr,   1'b1);
        step();
        check("t2_done",  done,     2'b10);
        check("t2_wroff", mem_wr,   1'b0);
        req = 2'b00;
        step();
        check("t2_ram0",  ram_rd(32'h1FFFF), 8'hEF);
        check("t2_ram1",  ram_rd(32'h20000), 8'hBE);

        // Byte loads with and without sign extension
        set_ch(1, 1'b0, 2'b00, 1'b1, 32'h30000, 32'h0);
        req = 2'b10;
        step();
        wait_done(20, c);
        check("t3s_lat",   c,     2);
        check("t3s_done",  done,  2'b10);
        check("t3s_rdata", rdata, 32'hFFFFFF80);
        req = 2'b00;
        step();
        set_ch(1, 1'b0, 2'b00, 1'b0, 32'h30000, 32'h0);
        req = 2'b10;
        step();
        wait_done(20, c);
        check("t3z_lat",   c,     2);
        check("t3z_rdata", rdata, 32'h00000080);
        req = 2'b00;
        step();

        // Both channels request continuously: grants must alternate
        set_ch(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        set_ch(1, 1'b0, 2'b00, 1'b0, 32'h30000, 32'h0);
        req = 2'b11;
        c = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(20, c2);
            check("t4_gap",   c + c2, (k == 0) ? 3 : 4);
            check("t4_grant", done,   (k % 2 == 0) ? 2'b01 : 2'b10);
            check("t4_rdata", rdata,  (k % 2 == 0) ? 32'h78 : 32'h80);
            if (k == 3) req = 2'b00;
            step();
            check("t4_pulse", done,   2'b00);
            c = 1;
        end

        // Word load with a three-cycle pause after byte 1 is issued
        set_ch(0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        req = 2'b01;
        step();
        step();
        check("t5_addr1", mem_addr, 32'h201);
        step();
        check("t5_addr2", mem_addr, 32'h202);
        rdy = 1'b0;
        step();
        check("t5_hold",  mem_addr, 32'h202);
        check("t5_busy",  busy,     1'b1);
        step();
        step();
        rdy = 1'b1;
        #1;
        check("t5_reiss", mem_addr, 32'h201);
        wait_done(20, c);
        check("t5_lat",   c + 5,    9);
        check("t5_done",  done,     2'b01);
        check("t5_rdata", rdata,    32'h44332211);
        req = 2'b00;
        step();

        // Reset in the middle of a word store
        set_ch(1, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D);
        req = 2'b10;
        step();
        check("t6_dout0", mem_dout, 8'h0D);
        step();
        check("t6_dout1", mem_dout, 8'hF0);
        step();
        check("t6_addr2", mem_addr, 32'h402);
        check("t6_dout2", mem_dout, 8'hFE);
        check("t6_wr2",   mem_wr,   1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rdone", done,     2'b00);
        check("t6_rbusy", busy,     1'b0);
        check("t6_raddr", mem_addr, 32'h0);
        check("t6_rwr",   mem_wr,   1'b0);
        check("t6_rdout", mem_dout, 8'h00);
        check("t6_rdata", rdata,    32'h0);
        req = 2'b00;
        step();
        step();
        check("t6_nodone", done,    2'b00);
        check("t6_ram0",  ram_rd(32'h400), 8'h0D);
        check("t6_ram2",  ram_rd(32'h402), 8'h00);
        rst_n = 1'b1;
        set_ch(1, 1'b0, 2'b01, 1'b0, 32'h400, 32'h0);
        req = 2'b10;
        step();
        wait_done(20, c);
        check("t6_lat",   c,     3);
        check("t6_done",  done,  2'b10);
        check("t6_rd",    rdata, 32'h0000F00D);
        req = 2'b00;
        step();
        check("t6_end",   busy,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
